// File: rtl/io_btn_conditioner.sv
// Pushbutton/switch conditioner: per-channel synchroniser, debounce, edge detect,
// software-cleared sticky event flags and a registered interrupt request.

module io_btn_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_clr,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_sticky
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic raw, sync, next_stable, rise_n, fall_n, evt;

  assign raw  = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;
  assign sync = sync_q[SYNC_STAGES-1];

  // o_level doubles as the debounced 'stable' register
  always_comb begin
    next_stable = o_level;
    if (sync != o_level && cnt == CNT_LAST) next_stable = sync;
    rise_n = next_stable & ~o_level;
    fall_n = ~next_stable & o_level;
    case (EDGE_MODE)
      0:       evt = rise_n;
      1:       evt = fall_n;
      default: evt = rise_n | fall_n;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= '0;
      cnt      <= '0;
      o_level  <= 1'b0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
      o_sticky <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (sync == o_level || cnt == CNT_LAST) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;
      o_level  <= next_stable;
      o_rise   <= rise_n;
      o_fall   <= fall_n;
      // a new event outranks a clear landing in the same cycle
      o_sticky <= (o_sticky & ~i_clr) | evt;
    end
  end
endmodule

module io_btn_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_btn,
  input  logic [NUM_CH-1:0] i_clr,
  input  logic [NUM_CH-1:0] i_irq_en,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_sticky,
  output logic              o_irq
);
  io_btn_ch #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .EDGE_MODE(EDGE_MODE), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_ch [NUM_CH-1:0] (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn), .i_clr(i_clr),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_sticky(o_sticky)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) o_irq <= 1'b0;
    else       o_irq <= |(o_sticky & i_irq_en);
  end
endmodule

// File: tb/tb_io_btn_conditioner.sv
// Scoreboard bench: default-parameter instance plus an 8-channel, 1-cycle debounce,
// 3-stage, both-edge, active-low instance, both checked against a window model.
module tb_io_btn_conditioner;
  localparam int S0 = 2, D0 = 16, S1 = 3, D1 = 1;
  localparam int LOGN = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] btn0, clr0, en0, lvl0, rise0, fall0, stk0;
  logic [7:0] btn1, clr1, en1, lvl1, rise1, fall1, stk1;
  logic       irq0, irq1;

  io_btn_conditioner dut0 (
    .i_clk(clk), .i_rst(rst), .i_btn(btn0), .i_clr(clr0), .i_irq_en(en0),
    .o_level(lvl0), .o_rise(rise0), .o_fall(fall0), .o_sticky(stk0), .o_irq(irq0));

  io_btn_conditioner #(.NUM_CH(8), .SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1),
                       .EDGE_MODE(2), .ACTIVE_LOW(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_btn(btn1), .i_clr(clr1), .i_irq_en(en1),
    .o_level(lvl1), .o_rise(rise1), .o_fall(fall1), .o_sticky(stk1), .o_irq(irq1));

  typedef struct packed {
    logic [7:0] lvl, rise, fall, stk;
    logic       irq;
  } obs_t;

  obs_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;

  // reference model: a new level is accepted once the synchronised input has
  // disagreed with it for a full window of edges since the last reset/acceptance
  int         cyc = 0;
  logic [7:0] raw_log [2][LOGN];
  int         rst_cyc [2];
  int         bnd     [2][8];
  logic [7:0] m_lvl [2], m_stk [2];
  logic       m_irq [2];

  function automatic logic sync_at(input int d, input int c, input int k, input int s);
    if (k - s > rst_cyc[d]) return raw_log[d][(k - s) % LOGN][c];
    return 1'b0;
  endfunction

  task automatic model_step(input int d, input logic r, input logic [7:0] raw,
                            input logic [7:0] clr, input logic [7:0] en);
    int s, dw, mode, nch;
    obs_t e;
    logic [7:0] evt;
    bit acc;
    s = d ? S1 : S0; dw = d ? D1 : D0; mode = d ? 2 : 0; nch = d ? 8 : 4;
    e = '0;
    evt = '0;
    if (r) begin
      rst_cyc[d] = cyc;
      for (int c = 0; c < 8; c++) bnd[d][c] = cyc;
      m_lvl[d] = '0; m_stk[d] = '0; m_irq[d] = 1'b0;
    end else begin
      raw_log[d][cyc % LOGN] = raw;
      m_irq[d] = |(m_stk[d] & en);
      for (int c = 0; c < nch; c++) begin
        acc = 1'b1;
        for (int k = cyc - dw + 1; k <= cyc; k++)
          if (k <= bnd[d][c] || sync_at(d, c, k, s) == m_lvl[d][c]) acc = 1'b0;
        if (acc) begin
          bnd[d][c] = cyc;
          if (m_lvl[d][c]) e.fall[c] = 1'b1; else e.rise[c] = 1'b1;
          m_lvl[d][c] = ~m_lvl[d][c];
        end
      end
      evt = (mode == 0) ? e.rise : (mode == 1) ? e.fall : (e.rise | e.fall);
      m_stk[d] = (m_stk[d] & ~clr) | evt;
    end
    e.lvl = m_lvl[d]; e.stk = m_stk[d]; e.irq = m_irq[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  initial begin
    rst_cyc[0] = 0; rst_cyc[1] = 0;
    for (int c = 0; c < 8; c++) begin bnd[0][c] = 0; bnd[1][c] = 0; end
    m_lvl[0] = '0; m_lvl[1] = '0; m_stk[0] = '0; m_stk[1] = '0;
    m_irq[0] = 1'b0; m_irq[1] = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0, rst, {4'b0, btn0}, {4'b0, clr0}, {4'b0, en0});
      model_step(1, rst, ~btn1, clr1, en1);
    end
  end

  // monitor: every cycle presents a full output set
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '{lvl: {4'b0, lvl0}, rise: {4'b0, rise0}, fall: {4'b0, fall0},
              stk: {4'b0, stk0}, irq: irq0};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL dut0 cyc %0d: got lvl=%h rise=%h fall=%h stk=%h irq=%b, want lvl=%h rise=%h fall=%h stk=%h irq=%b",
                   cyc, a.lvl, a.rise, a.fall, a.stk, a.irq, e.lvl, e.rise, e.fall, e.stk, e.irq);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '{lvl: lvl1, rise: rise1, fall: fall1, stk: stk1, irq: irq1};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL dut1 cyc %0d: got lvl=%h rise=%h fall=%h stk=%h irq=%b, want lvl=%h rise=%h fall=%h stk=%h irq=%b",
                   cyc, a.lvl, a.rise, a.fall, a.stk, a.irq, e.lvl, e.rise, e.fall, e.stk, e.irq);
        end
      end
    end
  end

  // cycles from the negedge on which the input changed until the pulse is seen
  task automatic meas(input int d, input int c, input bit want_rise, input int want,
                      input string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (d == 0) seen = want_rise ? rise0[c] : fall0[c];
      else        seen = want_rise ? rise1[c] : fall1[c];
    end
    n_cmp++;
    if (!seen || n != want) begin
      n_bad++;
      $display("FAIL %s: latency %0d (seen=%0d), want %0d", name, n, seen, want);
    end
  endtask

  task automatic check_bit(input logic act, input logic exp, input string name);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic clear_all();
    @(negedge clk); clr0 = 4'hF; clr1 = 8'hFF;
    @(negedge clk); clr0 = 4'h0; clr1 = 8'h00;
  endtask

  initial begin
    rst = 1'b1; btn0 = 4'hF; clr0 = 4'h0; en0 = 4'hF;
    btn1 = 8'hFF; clr1 = 8'h00; en1 = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    meas(0, 0, 1'b1, S0 + D0, "held_through_reset_rise");
    repeat (3) @(negedge clk);
    check_bit(irq0, 1'b1, "irq_after_reset_release");

    // clean press/release on ch3
    btn0 = 4'h0; repeat (30) @(negedge clk); clear_all();
    btn0[3] = 1'b1;
    meas(0, 3, 1'b1, S0 + D0, "ch3_press");
    repeat (40 - (S0 + D0)) @(negedge clk);
    btn0[3] = 1'b0;
    meas(0, 3, 1'b0, S0 + D0, "ch3_release");
    check_bit(stk0[3], 1'b1, "ch3_sticky");

    // bounce on ch1 then settle high
    for (int i = 0; i < 12; i++) begin
      btn0[1] = ~btn0[1];
      repeat (5) @(negedge clk);
    end
    btn0[1] = 1'b1;
    meas(0, 1, 1'b1, S0 + D0, "ch1_settle");

    // sticky clear and set-wins priority on ch2
    btn0 = 4'h0; repeat (30) @(negedge clk); clear_all();
    btn0[2] = 1'b1;
    meas(0, 2, 1'b1, S0 + D0, "ch2_press");
    @(negedge clk); clr0 = 4'b0100;
    @(negedge clk); clr0 = 4'b0000;
    check_bit(stk0[2], 1'b0, "ch2_cleared");
    @(negedge clk);
    check_bit(irq0, 1'b0, "irq_dropped");
    btn0[2] = 1'b0; repeat (30) @(negedge clk);
    btn0[2] = 1'b1;
    repeat (S0 + D0 - 1) @(negedge clk);
    clr0 = 4'b0100;
    @(negedge clk); clr0 = 4'b0000;
    check_bit(stk0[2], 1'b1, "set_wins_over_clear");

    // reset in the middle of a debounce count
    btn0 = 4'h0; repeat (30) @(negedge clk);
    btn0[0] = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_bit(lvl0[0], 1'b0, "level_after_mid_reset");
    meas(0, 0, 1'b1, S0 + D0, "rise_after_mid_reset");

    // swept instance, active-low ch5
    clear_all();
    btn1[5] = 1'b0;
    meas(1, 5, 1'b1, S1 + D1, "sweep_press");
    check_bit(lvl1[5], 1'b1, "sweep_level");
    @(negedge clk); clr1 = 8'h20;
    @(negedge clk); clr1 = 8'h00;
    btn1[5] = 1'b1;
    meas(1, 5, 1'b0, S1 + D1, "sweep_release");
    check_bit(stk1[5], 1'b1, "sweep_fall_sticky");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 11) == 0) btn0[c] = ~btn0[c];
      for (int c = 0; c < 8; c++) if ($urandom_range(0, 5) == 0) btn1[c] = ~btn1[c];
      clr0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      clr1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 49) == 0) en0 = 4'($urandom);
      if ($urandom_range(0, 49) == 0) en1 = 8'($urandom);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
